// File: rtl/psg_multi_channel.sv
// -----------------------------------------------------------------------------
// psg_multi_channel
//
// Programmable sound generator. It has NUM_TONE square-wave tone channels and
// one 16-bit Galois LFSR noise channel. Each channel has its own volume and
// enable bit. The gated volumes are summed, the sum saturates to the PWM range,
// and the result drives a PWM audio output. The duty only changes on a PWM
// frame boundary.
//
// Tone periods are double-buffered. A write commits a new period to the pending
// register, and the running channel picks it up only when its counter wraps.
// Retuning therefore never cuts a half-period short.
//
// Register map (write-only):
//   ch*4+0          period low byte (staged)
//   ch*4+1          period high bits; commits {high, staged low} to pending
//   ch*4+2          tone volume
//   NUM_TONE*4+0    noise volume
//   NUM_TONE*4+1    enable mask: bit i = tone i, bit NUM_TONE = noise
//   NUM_TONE*4+2    noise divider
//   ch*4+3, NUM_TONE*4+3 and all higher addresses are ignored.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high; wins over a same-cycle write
//   write_strobe  register write enable
//   address       register address
//   data          register write data
//   signal_out    registered PWM audio output
//   debug         low 8 bits of the applied PWM duty
// -----------------------------------------------------------------------------
module psg_multi_channel #(
   parameter int NUM_TONE = 4,
   parameter int PERIOD_W = 12,
   parameter int VOL_W    = 4,
   parameter int PWM_W    = 8,
   parameter int ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_strobe,
   input  logic [ADDR_W-1:0] address,
   input  logic [7:0]        data,
   output logic              signal_out,
   output logic [7:0]        debug
);

   localparam int          SUM_W     = VOL_W + $clog2(NUM_TONE + 1) + 1;
   localparam int          EN_W      = NUM_TONE + 1;
   localparam int          NOISE     = NUM_TONE;
   localparam int          DUTY_MAX  = (1 << PWM_W) - 1;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Configuration registers
   logic [7:0]          stage_q [NUM_TONE];
   logic [7:0]          stage_d [NUM_TONE];
   logic [PERIOD_W-1:0] pend_q  [NUM_TONE];
   logic [PERIOD_W-1:0] pend_d  [NUM_TONE];
   logic [VOL_W-1:0]    vol_q   [NUM_TONE];
   logic [VOL_W-1:0]    vol_d   [NUM_TONE];
   logic [VOL_W-1:0]    nvol_q, nvol_d;
   logic [EN_W-1:0]     en_q, en_d;
   logic [7:0]          ndiv_q, ndiv_d;

   // Tone channel state
   logic [PERIOD_W-1:0] act_q [NUM_TONE];
   logic [PERIOD_W-1:0] act_d [NUM_TONE];
   logic [PERIOD_W-1:0] cnt_q [NUM_TONE];
   logic [PERIOD_W-1:0] cnt_d [NUM_TONE];
   logic [NUM_TONE-1:0] wave_q, wave_d;

   // Noise channel state
   logic [7:0]          ndcnt_q, ndcnt_d;
   logic [15:0]         lfsr_q, lfsr_d;

   // Mixer / PWM
   logic [SUM_W-1:0]    sum;
   logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
   logic [PWM_W-1:0]    duty_q, duty_d;
   logic                sig_q, sig_d;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   function automatic logic [PWM_W-1:0] sat_duty(input logic [SUM_W-1:0] s);
      if (32'(s) > DUTY_MAX) return PWM_W'(DUTY_MAX);
      return PWM_W'(s);
   endfunction

   // Mixer: only channels that are enabled and currently high contribute
   always_comb begin
      sum = '0;
      for (int ch = 0; ch < NUM_TONE; ch++) begin
         if (en_q[ch] && wave_q[ch]) sum = sum + SUM_W'(vol_q[ch]);
      end
      if (en_q[NOISE] && lfsr_q[0]) sum = sum + SUM_W'(nvol_q);
   end

   always_comb begin
      stage_d   = stage_q;
      pend_d    = pend_q;
      vol_d     = vol_q;
      nvol_d    = nvol_q;
      en_d      = en_q;
      ndiv_d    = ndiv_q;
      act_d     = act_q;
      cnt_d     = cnt_q;
      wave_d    = wave_q;
      ndcnt_d   = ndcnt_q;
      lfsr_d    = lfsr_q;
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      duty_d    = duty_q;
      sig_d     = (pwm_cnt_q < duty_q);

      // Register bus. The commit uses the staged byte as it was before this
      // edge, so a low-byte write and a commit in consecutive cycles pair up.
      if (write_strobe) begin
         for (int ch = 0; ch < NUM_TONE; ch++) begin
            if (int'(address) == ch*4)     stage_d[ch] = data;
            if (int'(address) == ch*4 + 1) pend_d[ch]  = PERIOD_W'({data, stage_q[ch]});
            if (int'(address) == ch*4 + 2) vol_d[ch]   = VOL_W'(data);
         end
         if (int'(address) == NUM_TONE*4)     nvol_d = VOL_W'(data);
         if (int'(address) == NUM_TONE*4 + 1) en_d   = EN_W'({8'h00, data});
         if (int'(address) == NUM_TONE*4 + 2) ndiv_d = data;
      end

      // Tones. The active period reloads from pending only while idle or on a
      // wrap, and it always reads the pre-edge pending value.
      for (int ch = 0; ch < NUM_TONE; ch++) begin
         if (!en_q[ch] || act_q[ch] == '0) begin
            cnt_d[ch]  = '0;
            wave_d[ch] = 1'b0;
            act_d[ch]  = pend_q[ch];
         end else if (cnt_q[ch] == act_q[ch] - PERIOD_W'(1)) begin
            cnt_d[ch]  = '0;
            wave_d[ch] = ~wave_q[ch];
            act_d[ch]  = pend_q[ch];
         end else begin
            cnt_d[ch]  = cnt_q[ch] + PERIOD_W'(1);
         end
      end

      // Noise: the divider and LFSR freeze while the channel is disabled
      if (en_q[NOISE]) begin
         if (ndcnt_q == ndiv_q) begin
            ndcnt_d = '0;
            lfsr_d  = lfsr_step(lfsr_q);
         end else begin
            ndcnt_d = ndcnt_q + 8'd1;
         end
      end

      // The duty only changes on the last count of a frame, so a frame is never split
      if (pwm_cnt_q == PWM_W'(DUTY_MAX)) duty_d = sat_duty(sum);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q   <= '{default: '0};
         pend_q    <= '{default: '0};
         vol_q     <= '{default: '0};
         nvol_q    <= '0;
         en_q      <= '0;
         ndiv_q    <= '0;
         act_q     <= '{default: '0};
         cnt_q     <= '{default: '0};
         wave_q    <= '0;
         ndcnt_q   <= '0;
         lfsr_q    <= LFSR_SEED;
         pwm_cnt_q <= '0;
         duty_q    <= '0;
         sig_q     <= 1'b0;
      end else begin
         stage_q   <= stage_d;
         pend_q    <= pend_d;
         vol_q     <= vol_d;
         nvol_q    <= nvol_d;
         en_q      <= en_d;
         ndiv_q    <= ndiv_d;
         act_q     <= act_d;
         cnt_q     <= cnt_d;
         wave_q    <= wave_d;
         ndcnt_q   <= ndcnt_d;
         lfsr_q    <= lfsr_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         sig_q     <= sig_d;
      end
   end

   assign signal_out = sig_q;
   assign debug      = 8'(duty_q);

endmodule

// File: tb/tb_psg_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_psg_multi_channel
//
// Bench for psg_multi_channel. The DUT runs with a 6-bit PWM so that five
// full-volume channels can drive the mixer into saturation. A reference model
// of the generator advances once per clock and is compared every cycle. The
// bench also has a table of register writes with fixed expected duty values,
// and directed sequences for retuning, saturation, noise and reset.
// -----------------------------------------------------------------------------
module tb_psg_multi_channel;

   localparam int NT   = 4;
   localparam int PW   = 12;
   localparam int PWMW = 6;
   localparam int FMAX = (1 << PWMW) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       write_strobe;
   logic [4:0] address;
   logic [7:0] data;
   logic       signal_out;
   logic [7:0] debug;

   psg_multi_channel #(
      .NUM_TONE(NT), .PERIOD_W(PW), .VOL_W(4), .PWM_W(PWMW), .ADDR_W(5)
   ) dut (
      .clk(clk), .rst(rst), .write_strobe(write_strobe), .address(address),
      .data(data), .signal_out(signal_out), .debug(debug)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int seg_err = 0;
   int toggles = 0;
   logic prev_sig = 1'b0;

   // Reference model state
   int m_stage[NT], m_pend[NT], m_act[NT], m_cnt[NT], m_wave[NT], m_vol[NT];
   int m_nvol, m_en, m_ndiv, m_ndcnt, m_lfsr, m_pwm, m_duty, m_sig;

   function automatic bool_en(input int bitpos);
      return ((m_en >> bitpos) & 1) != 0;
   endfunction

   function automatic void model_step(input bit r, input bit ws, input int a_in, input int d_in);
      int sum, a, d;
      a = a_in & 31;
      d = d_in & 255;
      if (r) begin
         for (int i = 0; i < NT; i++) begin
            m_stage[i] = 0; m_pend[i] = 0; m_act[i] = 0;
            m_cnt[i] = 0; m_wave[i] = 0; m_vol[i] = 0;
         end
         m_nvol = 0; m_en = 0; m_ndiv = 0; m_ndcnt = 0;
         m_lfsr = 'hACE1; m_pwm = 0; m_duty = 0; m_sig = 0;
         return;
      end
      // Everything below reacts to the state seen before this clock edge
      sum = 0;
      for (int i = 0; i < NT; i++) if (bool_en(i) && m_wave[i] != 0) sum += m_vol[i];
      if (bool_en(NT) && (m_lfsr & 1) != 0) sum += m_nvol;
      m_sig = (m_pwm < m_duty) ? 1 : 0;
      if (m_pwm == FMAX) m_duty = (sum > FMAX) ? FMAX : sum;
      m_pwm = (m_pwm + 1) % (FMAX + 1);
      if (bool_en(NT)) begin
         if (m_ndcnt == m_ndiv) begin
            m_ndcnt = 0;
            m_lfsr = ((m_lfsr & 1) != 0) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
         end else begin
            m_ndcnt = (m_ndcnt + 1) % 256;
         end
      end
      for (int i = 0; i < NT; i++) begin
         if (!bool_en(i) || m_act[i] == 0) begin
            m_cnt[i] = 0; m_wave[i] = 0; m_act[i] = m_pend[i];
         end else if (m_cnt[i] == m_act[i] - 1) begin
            m_cnt[i] = 0; m_wave[i] = 1 - m_wave[i]; m_act[i] = m_pend[i];
         end else begin
            m_cnt[i]++;
         end
      end
      if (ws) begin
         if (a < NT*4) begin
            case (a % 4)
               0: m_stage[a/4] = d;
               1: m_pend[a/4]  = ((d & ((1 << (PW-8)) - 1)) << 8) | m_stage[a/4];
               2: m_vol[a/4]   = d & 15;
               default: ;
            endcase
         end else if (a == NT*4)     m_nvol = d & 15;
         else if (a == NT*4 + 1)     m_en   = d & ((1 << (NT+1)) - 1);
         else if (a == NT*4 + 2)     m_ndiv = d;
      end
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // One clock: drive inputs, let the edge pass, update the model, then
   // compare the outputs half a cycle later.
   task automatic cyc(input bit r, input bit ws, input int a, input int d);
      rst          = r;
      write_strobe = ws;
      address      = 5'(a);
      data         = 8'(d);
      @(posedge clk);
      model_step(r, ws, a, d);
      @(negedge clk);
      if (signal_out !== m_sig[0] || debug !== 8'(m_duty)) seg_err++;
      if (signal_out !== prev_sig) toggles++;
      prev_sig = signal_out;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
   endtask

   typedef struct {
      int    addr;
      int    dat;
      int    wait_c;
      int    exp_dbg;
      string name;
   } vec_t;

   vec_t vt[10];

   initial begin
      int k, bad, seen0, seen15, hi, maxd, a, d;

      // Noise held at lfsr[0]=1 by a slow divider, so the expected duty is
      // just the gated noise volume.
      vt[0] = '{16, 'h09, 70, 0, "T0 nvol while disabled"};
      vt[1] = '{18, 'hFF, 70, 0, "T1 ndiv while disabled"};
      vt[2] = '{17, 'h10, 70, 9, "T2 noise enabled"};
      vt[3] = '{16, 'hF7, 70, 7, "T3 nvol upper bits ignored"};
      vt[4] = '{19, 'h0F, 70, 7, "T4 reserved addr"};
      vt[5] = '{17, 'h00, 70, 0, "T5 noise disabled"};
      vt[6] = '{24, 'hFF, 70, 0, "T6 unmapped addr"};
      vt[7] = '{ 2, 'h0C, 70, 0, "T7 vol0 tone disabled"};
      vt[8] = '{17, 'h01, 70, 0, "T8 tone0 enabled period 0"};
      vt[9] = '{ 0, 'h05, 70, 0, "T9 stage without commit"};

      // A: reset then idle
      do_reset();
      check("A reset signal_out", signal_out, 0);
      check("A reset debug", debug, 0);
      seg_err = 0; toggles = 0;
      idle(1000);
      check("A idle signal_out", signal_out, 0);
      check("A idle debug", debug, 0);
      check("A idle toggles", toggles, 0);
      check("A model", seg_err, 0);

      // Table vectors
      seg_err = 0;
      foreach (vt[i]) begin
         cyc(0, 1, vt[i].addr, vt[i].dat);
         idle(vt[i].wait_c);
         check(vt[i].name, debug, vt[i].exp_dbg);
      end
      check("T model", seg_err, 0);

      // B: tone 0 period 3, volume 15
      do_reset();
      seg_err = 0; bad = 0; seen0 = 0; seen15 = 0;
      cyc(0, 1, 0, 3); cyc(0, 1, 1, 0); cyc(0, 1, 2, 'h0F); cyc(0, 1, 17, 'h01);
      for (int i = 0; i < 1024; i++) begin
         cyc(0, 0, 0, 0);
         if (debug == 15) seen15++;
         else if (debug == 0) seen0++;
         else bad++;
      end
      check("B debug only 0/15", bad, 0);
      check("B debug reaches 15", seen15 > 0, 1);
      check("B debug reaches 0", seen0 > 0, 1);
      check("B model", seg_err, 0);

      // C: retune mid half-period, then commit on a wrap cycle
      do_reset();
      seg_err = 0;
      cyc(0, 1, 0, 100); cyc(0, 1, 1, 0); cyc(0, 1, 2, 'h0F); cyc(0, 1, 17, 'h01);
      k = 0;
      while (m_cnt[0] != 50 && k < 500) begin cyc(0, 0, 0, 0); k++; end
      check("C reach counter 50", k < 500, 1);
      cyc(0, 1, 0, 10);
      cyc(0, 1, 1, 0);
      idle(1500);
      cyc(0, 1, 0, 20);
      k = 0;
      while (!(m_act[0] != 0 && m_cnt[0] == m_act[0] - 1) && k < 100) begin
         cyc(0, 0, 0, 0); k++;
      end
      check("C reach wrap", k < 100, 1);
      cyc(0, 1, 1, 0);
      idle(1500);
      check("C model", seg_err, 0);

      // D: saturation, all tones period 1 + noise, all volume 15
      do_reset();
      seg_err = 0; maxd = 0;
      for (int ch = 0; ch < NT; ch++) begin
         cyc(0, 1, ch*4, 1); cyc(0, 1, ch*4 + 1, 0); cyc(0, 1, ch*4 + 2, 'h0F);
      end
      cyc(0, 1, 16, 'h0F);
      cyc(0, 1, 18, 'hFF);
      // Enable on an odd PWM count so frame boundaries sample the waves high
      k = 0;
      while ((m_pwm % 2) == 0 && k < 4) begin cyc(0, 0, 0, 0); k++; end
      cyc(0, 1, 17, 'h1F);
      for (int i = 0; i < 130; i++) begin
         cyc(0, 0, 0, 0);
         if (debug > maxd) maxd = debug;
      end
      check("D debug saturated", debug, FMAX);
      check("D max debug", maxd, FMAX);
      hi = 0;
      for (int i = 0; i < 64; i++) begin
         cyc(0, 0, 0, 0);
         if (signal_out) hi++;
      end
      check("D high per frame", hi, FMAX);
      check("D model", seg_err, 0);

      // E: noise only, divider 3, 4096 LFSR steps
      do_reset();
      seg_err = 0; bad = 0;
      cyc(0, 1, 16, 'h0F); cyc(0, 1, 18, 3); cyc(0, 1, 17, 1 << NT);
      for (int i = 0; i < 4096*4; i++) begin
         cyc(0, 0, 0, 0);
         if (debug != 0 && debug != 15) bad++;
      end
      check("E debug only 0/15", bad, 0);
      check("E model", seg_err, 0);

      // F: reset while everything runs, with a same-cycle volume write
      seg_err = 0;
      for (int ch = 0; ch < NT; ch++) begin
         cyc(0, 1, ch*4, ch + 2); cyc(0, 1, ch*4 + 1, 0); cyc(0, 1, ch*4 + 2, 'h0F);
      end
      cyc(0, 1, 17, 'h1F);
      idle(200);
      cyc(1, 1, 16, 'h0F);
      check("F signal_out after reset", signal_out, 0);
      check("F debug after reset", debug, 0);
      cyc(0, 1, 17, 1 << NT);
      maxd = 0; toggles = 0;
      for (int i = 0; i < 300; i++) begin
         cyc(0, 0, 0, 0);
         if (debug > maxd) maxd = debug;
      end
      check("F write discarded", maxd, 0);
      check("F no toggles", toggles, 0);
      check("F model", seg_err, 0);

      // G: random register traffic with occasional resets
      do_reset();
      seg_err = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            cyc(1, 0, 0, 0);
         end else if ($urandom_range(0, 3) == 0) begin
            a = int'($urandom_range(0, 31));
            d = int'($urandom_range(0, 255));
            if (a < NT*4 && (a % 4) == 1) d = int'($urandom_range(0, 1));
            if (a < NT*4 && (a % 4) == 0) d = int'($urandom_range(0, 40));
            cyc(0, 1, a, d);
         end else begin
            cyc(0, 0, 0, 0);
         end
      end
      check("G random model", seg_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule
